// File: rtl/imem_responder.sv
// Instruction-memory responder: reads a preloadable word array for each fetch and returns
// words in request order through a squashable FIFO. Every accepted fetch has a FIFO slot reserved.
module imem_responder #(
    parameter int N_BITS      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_BITS-1:0] i_req_addr,
    input  logic              i_req_vld,
    output logic              o_req_rdy,
    input  logic              i_squash_in,
    output logic [N_BITS-1:0] o_resp_data,
    output logic [N_BITS-1:0] o_resp_addr,
    output logic              o_resp_err,
    output logic              o_resp_vld,
    input  logic              i_resp_rdy,
    input  logic              i_wr_en,
    input  logic [N_BITS-1:0] i_wr_addr,
    input  logic [N_BITS-1:0] i_wr_data
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;
    localparam int NS = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam logic [N_BITS-1:0] NOP_WORD = N_BITS'(32'h0000_0013);

    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic [N_BITS-1:0] w_push_addr;
    logic              w_push_err;
    logic [N_BITS-1:0] w_push_raw;
    logic [N_BITS-1:0] w_push_data;
    logic [CW-1:0]     w_infl_cnt;
    logic [OW-1:0]     w_occ;
    logic [IW-1:0]     w_rd_idx;
    logic [IW-1:0]     w_wr_idx;
    logic              w_unused_wr_bits;

    logic [N_BITS-1:0] r_mem [DEPTH_WORDS];

    logic [N_BITS-1:0] r_fifo_data [FIFO_DEPTH];
    logic [N_BITS-1:0] r_fifo_addr [FIFO_DEPTH];
    logic              r_fifo_err  [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_fifo_cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Addresses alias modulo the array size; the write port ignores the same bits.
    assign w_rd_idx         = i_req_addr[IW+1:2];
    assign w_wr_idx         = i_wr_addr[IW+1:2];
    assign w_unused_wr_bits = &{1'b0, i_wr_addr[N_BITS-1:IW+2], i_wr_addr[1:0]};

    assign w_occ      = OW'(r_fifo_cnt) + OW'(w_infl_cnt);
    assign o_req_rdy  = i_squash_in | (w_occ < OW'(FIFO_DEPTH));
    assign w_accept   = i_req_vld & o_req_rdy;
    assign o_resp_vld = (r_fifo_cnt != '0);
    assign w_pop      = o_resp_vld & i_resp_rdy;

    generate
        if (LATENCY > 1) begin : g_piped
            logic [N_BITS-1:0] r_rd_data;
            logic [CW-1:0]     r_infl_cnt;
            logic              w_stg_vld  [NS];
            logic [N_BITS-1:0] w_stg_addr [NS];
            logic              w_stg_err  [NS];
            logic [N_BITS-1:0] w_stg_data [NS];

            // Read-before-write: a same-edge write to the fetched index returns the old word.
            always_ff @(posedge i_clk) begin
                if (w_accept) begin
                    r_rd_data <= r_mem[w_rd_idx];
                end
                if (i_wr_en) begin
                    r_mem[w_wr_idx] <= i_wr_data;
                end
            end

            for (genvar gi = 0; gi < NS; gi++) begin : g_stg
                logic              r_vld;
                logic [N_BITS-1:0] r_addr;
                logic              r_err;
                logic              w_in_vld;
                logic [N_BITS-1:0] w_in_addr;
                logic              w_in_err;

                if (gi == 0) begin : g_first
                    assign w_in_vld       = w_accept;
                    assign w_in_addr      = i_req_addr;
                    assign w_in_err       = |i_req_addr[1:0];
                    assign w_stg_data[gi] = r_rd_data;
                end else begin : g_later
                    logic [N_BITS-1:0] r_data;
                    // Squash kills older fetches; the redirect target sits in stage 0.
                    assign w_in_vld  = w_stg_vld[gi-1] & ~i_squash_in;
                    assign w_in_addr = w_stg_addr[gi-1];
                    assign w_in_err  = w_stg_err[gi-1];
                    always_ff @(posedge i_clk) begin
                        r_data <= w_stg_data[gi-1];
                    end
                    assign w_stg_data[gi] = r_data;
                end

                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_vld  <= 1'b0;
                        r_addr <= '0;
                        r_err  <= 1'b0;
                    end else begin
                        r_vld  <= w_in_vld;
                        r_addr <= w_in_addr;
                        r_err  <= w_in_err;
                    end
                end

                assign w_stg_vld[gi]  = r_vld;
                assign w_stg_addr[gi] = r_addr;
                assign w_stg_err[gi]  = r_err;
            end

            assign w_push      = w_stg_vld[NS-1] & ~i_squash_in;
            assign w_push_addr = w_stg_addr[NS-1];
            assign w_push_err  = w_stg_err[NS-1];
            assign w_push_raw  = w_stg_data[NS-1];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_infl_cnt <= '0;
                end else if (i_squash_in) begin
                    r_infl_cnt <= CW'(w_accept);
                end else begin
                    r_infl_cnt <= r_infl_cnt + CW'(w_accept) - CW'(w_stg_vld[NS-1]);
                end
            end
            assign w_infl_cnt = r_infl_cnt;
        end else begin : g_direct
            always_ff @(posedge i_clk) begin
                if (i_wr_en) begin
                    r_mem[w_wr_idx] <= i_wr_data;
                end
            end
            assign w_push      = w_accept;
            assign w_push_addr = i_req_addr;
            assign w_push_err  = |i_req_addr[1:0];
            assign w_push_raw  = r_mem[w_rd_idx];
            assign w_infl_cnt  = '0;
        end
    endgenerate

    assign w_push_data = w_push_err ? NOP_WORD : w_push_raw;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_fifo_data[k] <= '0;
                r_fifo_addr[k] <= '0;
                r_fifo_err[k]  <= 1'b0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else if (i_squash_in) begin
            // Only a zero-latency redirect target can push during a squash.
            r_rd_ptr <= '0;
            if (w_push) begin
                r_fifo_data[0] <= w_push_data;
                r_fifo_addr[0] <= w_push_addr;
                r_fifo_err[0]  <= w_push_err;
                r_wr_ptr       <= ptr_inc('0);
                r_fifo_cnt     <= CW'(1);
            end else begin
                r_wr_ptr   <= '0;
                r_fifo_cnt <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_fifo_addr[r_wr_ptr] <= w_push_addr;
                r_fifo_err[r_wr_ptr]  <= w_push_err;
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_resp_data = r_fifo_data[r_rd_ptr];
    assign o_resp_addr = r_fifo_addr[r_rd_ptr];
    assign o_resp_err  = r_fifo_err[r_rd_ptr];

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: expected responses are queued at acceptance from a
// word-array model and checked in order by an independent monitor.
module tb_imem_responder;
    localparam int NB  = 32;
    localparam int DW  = 1024;
    localparam int LAT = 2;
    localparam int FD  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] req_addr;
    logic        req_vld;
    logic        req_rdy;
    logic        squash;
    logic [31:0] resp_data;
    logic [31:0] resp_addr;
    logic        resp_err;
    logic        resp_vld;
    logic        resp_rdy;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          acc_edge;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [DW];

    imem_responder #(
        .N_BITS(NB), .DEPTH_WORDS(DW), .LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_addr(req_addr), .i_req_vld(req_vld), .o_req_rdy(req_rdy),
        .i_squash_in(squash),
        .o_resp_data(resp_data), .o_resp_addr(resp_addr), .o_resp_err(resp_err),
        .o_resp_vld(resp_vld), .i_resp_rdy(resp_rdy),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int word_index(input logic [31:0] a);
        return int'((a / 4) % DW);
    endfunction

    // Capture: decides what the next edge does and records the expected response.
    initial begin : capture
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                sb_q.delete();
                continue;
            end
            if (squash) sb_q.delete();
            if (req_vld && req_rdy) begin
                e.addr     = req_addr;
                e.err      = (req_addr % 4) != 0;
                e.data     = e.err ? NOP : model_mem[word_index(req_addr)];
                e.acc_edge = cyc + 1;
                sb_q.push_back(e);
            end
            if (wr_en) model_mem[word_index(wr_addr)] = wr_data;
        end
    end

    // Monitor: every handshake pops and compares the oldest expected response.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && resp_vld) begin
            check("resp_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0 && resp_rdy) begin
                e = sb_q.pop_front();
                $display("resp addr=%h data=%h err=%0d", resp_addr, resp_data, resp_err);
                check("resp_addr", resp_addr, e.addr);
                check("resp_data", resp_data, e.data);
                check("resp_err", 32'(resp_err), 32'(e.err));
                check("resp_latency", 32'(cyc >= e.acc_edge + LAT - 1), 32'd1);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drain(input string name);
        int n;
        req_vld  = 1'b0;
        squash   = 1'b0;
        wr_en    = 1'b0;
        resp_rdy = 1'b1;
        n = 0;
        while ((sb_q.size() != 0 || resp_vld) && n < 100) begin
            step();
            n++;
        end
        repeat (2) step();
        check({"drain_", name}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin : stim
        int acc;
        logic [31:0] a;
        rst_n = 1'b1; req_addr = '0; req_vld = 1'b0; squash = 1'b0;
        resp_rdy = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #2 rst_n = 1'b0;
        #2;
        check("rst_resp_vld", 32'(resp_vld), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_addr", resp_addr, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_rdy", 32'(req_rdy), 32'd1);

        // Preload words 0..63.
        step();
        for (int i = 0; i < 64; i++) begin
            wr_en   = 1'b1;
            wr_addr = 32'(i) * 4;
            wr_data = (i == 0) ? 32'h0050_0093 : (i == 1) ? 32'h00A0_0113 : $urandom();
            step();
        end
        wr_en = 1'b0;

        // Back-to-back fetches with an always-ready consumer.
        resp_rdy = 1'b1; req_vld = 1'b1; req_addr = 32'h0;
        step();
        req_addr = 32'h4;
        @(negedge clk);
        check("t1_vld_before_latency", 32'(resp_vld), 32'd0);
        step();
        req_vld = 1'b0;
        @(negedge clk);
        check("t1_vld_first", 32'(resp_vld), 32'd1);
        check("t1_data_first", resp_data, 32'h0050_0093);
        step();
        @(negedge clk);
        check("t1_vld_second", 32'(resp_vld), 32'd1);
        check("t1_data_second", resp_data, 32'h00A0_0113);
        step();
        @(negedge clk);
        check("t1_vld_idle", 32'(resp_vld), 32'd0);
        drain("t1");

        // Back-pressure: exactly FIFO_DEPTH fetches accepted.
        resp_rdy = 1'b0; req_vld = 1'b1; acc = 0;
        for (int i = 0; i < 8; i++) begin
            req_addr = 32'h20 + 32'(i) * 4;
            @(negedge clk);
            if (req_rdy) acc++;
            step();
        end
        check("t2_accepts", 32'(acc), 32'(FD));
        req_vld = 1'b0; resp_rdy = 1'b1;
        @(negedge clk);
        check("t2_full_rdy", 32'(req_rdy), 32'd0);
        step();
        @(negedge clk);
        check("t2_rdy_back", 32'(req_rdy), 32'd1);
        drain("t2");

        // Squash with a redirect target in the squash cycle.
        resp_rdy = 1'b0; req_vld = 1'b1;
        req_addr = 32'h10; step();
        req_addr = 32'h14; step();
        req_addr = 32'h18; step();
        squash = 1'b1; req_addr = 32'h40;
        @(negedge clk);
        check("t3_squash_rdy", 32'(req_rdy), 32'd1);
        step();
        squash = 1'b0; req_vld = 1'b0;
        @(negedge clk);
        check("t3_vld_cleared", 32'(resp_vld), 32'd0);
        resp_rdy = 1'b1;
        step();
        @(negedge clk);
        check("t3_target_vld", 32'(resp_vld), 32'd1);
        check("t3_target_addr", resp_addr, 32'h40);
        drain("t3");

        // Misaligned fetch, alias, and same-cycle write/read.
        req_vld = 1'b1; req_addr = 32'h6; step();
        req_addr = 32'h1000; step();
        req_addr = 32'h14; wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'hCAFE_F00D; step();
        wr_en = 1'b0; step();
        drain("t5");

        // Reset while responses are queued and in flight.
        resp_rdy = 1'b0; req_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'h80 + 32'(i) * 4;
            step();
        end
        req_vld = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_vld", 32'(resp_vld), 32'd0);
        check("t6_rst_data", resp_data, 32'd0);
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rdy_after", 32'(req_rdy), 32'd1);
        resp_rdy = 1'b1;
        repeat (6) step();
        check("t6_no_stale", 32'(resp_vld), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            a = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            req_addr = a;
            req_vld  = ($urandom_range(0, 3) != 0);
            resp_rdy = ($urandom_range(0, 2) != 0);
            squash   = ($urandom_range(0, 24) == 0);
            wr_en    = ($urandom_range(0, 5) == 0);
            wr_addr  = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2);
            wr_data  = $urandom();
            step();
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
